// File: rtl/fir_sequencer.sv
// ============================================================================
// Module      : fir_sequencer
// Description : Time-multiplexed FIR controller driving one external
//               multiply-accumulate ALU, one tap per ALU transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sequencer #(
    parameter int NUM_TAPS = 8,
    parameter int ALU_LAT  = 3,
    parameter int IDX_W    = $clog2(NUM_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    input  logic             coef_we,
    input  logic [IDX_W-1:0] coef_addr,
    input  logic [15:0]      coef_data,
    output logic [1:0]       alu_op,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [31:0]      alu_acc,
    input  logic [31:0]      alu_result,
    output logic             y_valid,
    output logic [31:0]      y_data,
    output logic             busy
);

    localparam int c_CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [1:0] c_OP_MAC  = 2'b00;
    localparam logic [1:0] c_OP_ZERO = 2'b10;

    logic [1:0]         r_state;
    logic [15:0]        r_x [NUM_TAPS];
    logic [15:0]        r_h [NUM_TAPS];
    logic [31:0]        r_acc;
    logic [IDX_W-1:0]   r_tap_idx;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [31:0]        r_y_data;
    logic               r_y_valid;

    logic               w_coef_ok;
    logic               w_last_tap;

    assign w_coef_ok  = coef_we && (int'(coef_addr) < NUM_TAPS);
    assign w_last_tap = (r_tap_idx == IDX_W'(NUM_TAPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_acc      <= '0;
            r_tap_idx  <= '0;
            r_wait_cnt <= '0;
            r_y_data   <= '0;
            r_y_valid  <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_x[k] <= '0;
                r_h[k] <= '0;
            end
        end else begin
            r_y_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // Coefficient write lands at this edge, so a sample accepted
                    // alongside it already sees the new value in its first ISSUE.
                    if (w_coef_ok) begin
                        r_h[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        for (int k = NUM_TAPS - 1; k >= 1; k--) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_x[0]    <= in_data;
                        r_acc     <= '0;
                        r_tap_idx <= '0;
                        r_state   <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_wait_cnt <= c_CNT_W'(ALU_LAT - 1);
                    r_state    <= c_WAIT;
                end
                c_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_acc <= alu_result;
                        if (w_last_tap) begin
                            r_state <= c_DONE;
                        end else begin
                            r_tap_idx <= r_tap_idx + 1'b1;
                            r_state   <= c_ISSUE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                c_DONE: begin
                    r_y_data  <= r_acc;
                    r_y_valid <= 1'b1;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Operands stay constant from ISSUE through the whole WAIT window because
    // tap index and accumulator only change on the final WAIT edge.
    always_comb begin
        alu_op  = c_OP_ZERO;
        alu_a   = '0;
        alu_b   = '0;
        alu_acc = '0;
        if (r_state == c_ISSUE || r_state == c_WAIT) begin
            alu_op  = c_OP_MAC;
            alu_a   = r_x[r_tap_idx];
            alu_b   = r_h[r_tap_idx];
            alu_acc = r_acc;
        end
    end

    assign in_ready = (r_state == c_IDLE);
    assign busy     = (r_state != c_IDLE);
    assign y_valid  = r_y_valid;
    assign y_data   = r_y_data;

endmodule

`default_nettype wire
